round_timer: RTL and testbench

//  Boxing round/rest countdown sequencer, directly downstream of the clock divider.

---
 rtl/round_timer.sv | 149 ++++++++++++++
 tb/tb_round_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_timer.sv
// Boxing round/rest countdown sequencer: BCD M:SS display, round counter and bell,
// advanced by rising edges of the divider's slow tick, all on clkin.
module round_timer #(
    parameter int ROUND_TIME = 180,
    parameter int REST_TIME  = 60,
    parameter int NUM_ROUNDS = 3,
    parameter int BELL_LEN   = 4
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] round_num,
    output logic [1:0] phase,
    output logic       paused,
    output logic       bell,
    output logic       done
);

    localparam int BW = (BELL_LEN < 2) ? 1 : $clog2(BELL_LEN + 1);

    localparam logic [3:0] RND_M = 4'(ROUND_TIME / 60);
    localparam logic [3:0] RND_T = 4'((ROUND_TIME % 60) / 10);
    localparam logic [3:0] RND_O = 4'(ROUND_TIME % 10);
    localparam logic [3:0] RST_M = 4'(REST_TIME / 60);
    localparam logic [3:0] RST_T = 4'((REST_TIME % 60) / 10);
    localparam logic [3:0] RST_O = 4'(REST_TIME % 10);
    localparam logic [3:0] LAST  = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FIGHT = 2'b01,
        REST  = 2'b10,
        DONE  = 2'b11
    } phase_t;

    phase_t        state, state_nx;
    logic [3:0]    min_nx, tens_nx, ones_nx, round_nx;
    logic          paused_nx;
    logic          ring;
    logic          tick_q;
    logic          tick_e;
    logic          time_zero;
    logic [BW-1:0] bell_cnt;

    // One-second BCD decrement of {minutes, tens, ones} with borrow chain.
    function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] t,
                                            input logic [3:0] o);
        logic [3:0] mo, to, oo;
        mo = m;
        to = t;
        oo = o;
        if (o != 4'd0) begin
            oo = o - 4'd1;
        end else begin
            oo = 4'd9;
            if (t != 4'd0) begin
                to = t - 4'd1;
            end else begin
                to = 4'd5;
                mo = m - 4'd1;
            end
        end
        return {mo, to, oo};
    endfunction

    assign tick_e    = tick_in & ~tick_q;
    assign time_zero = (min_bcd == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);

    always_comb begin
        state_nx  = state;
        min_nx    = min_bcd;
        tens_nx   = sec_tens;
        ones_nx   = sec_ones;
        round_nx  = round_num;
        paused_nx = paused;
        ring      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FIGHT;
                    ring     = 1'b1;
                end
            end
            FIGHT, REST: begin
                if (pause) paused_nx = ~paused;
                // The tick is gated by the paused value held before this cycle's toggle.
                if (tick_e && !paused) begin
                    if (!time_zero) begin
                        {min_nx, tens_nx, ones_nx} = bcd_dec(min_bcd, sec_tens, sec_ones);
                    end else if (state == FIGHT && round_num == LAST) begin
                        state_nx  = DONE;
                        paused_nx = 1'b0;
                        ring      = 1'b1;
                    end else if (state == FIGHT) begin
                        state_nx = REST;
                        {min_nx, tens_nx, ones_nx} = {RST_M, RST_T, RST_O};
                        ring     = 1'b1;
                    end else begin
                        state_nx = FIGHT;
                        round_nx = round_num + 4'd1;
                        {min_nx, tens_nx, ones_nx} = {RND_M, RND_T, RND_O};
                        ring     = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_nx = IDLE;
                    round_nx = 4'd1;
                    {min_nx, tens_nx, ones_nx} = {RND_M, RND_T, RND_O};
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!rst) begin
            state     <= IDLE;
            min_bcd   <= RND_M;
            sec_tens  <= RND_T;
            sec_ones  <= RND_O;
            round_num <= 4'd1;
            paused    <= 1'b0;
            tick_q    <= 1'b1;
            bell_cnt  <= '0;
        end else begin
            state     <= state_nx;
            min_bcd   <= min_nx;
            sec_tens  <= tens_nx;
            sec_ones  <= ones_nx;
            round_num <= round_nx;
            paused    <= paused_nx;
            tick_q    <= tick_in;
            if (ring) bell_cnt <= BW'(BELL_LEN);
            else if (bell_cnt != '0) bell_cnt <= bell_cnt - BW'(1);
        end
    end

    assign phase = state;
    assign bell  = (bell_cnt != '0);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_round_timer.sv
// Bench for round_timer: directed sequence plus random start/pause/reset traffic,
// compared cycle by cycle against an integer-seconds model of the match.
module tb_round_timer;

    localparam int RT = 3;
    localparam int RS = 2;
    localparam int NR = 2;
    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_in = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] min_bcd, sec_tens, sec_ones, round_num;
    logic [1:0] phase;
    logic       paused, bell, done;

    logic       tick2 = 1'b1;
    logic       start2 = 1'b0;
    logic       pause2 = 1'b0;
    logic [3:0] min2, tens2, ones2, round2;
    logic [1:0] phase2;
    logic       paused2, bell2, done2;

    round_timer #(.ROUND_TIME(RT), .REST_TIME(RS), .NUM_ROUNDS(NR), .BELL_LEN(BL)) dut (
        .clkin(clk), .rst(rst), .tick_in(tick_in), .start(start), .pause(pause),
        .min_bcd(min_bcd), .sec_tens(sec_tens), .sec_ones(sec_ones), .round_num(round_num),
        .phase(phase), .paused(paused), .bell(bell), .done(done)
    );

    round_timer #(.ROUND_TIME(599), .REST_TIME(RS), .NUM_ROUNDS(NR), .BELL_LEN(BL)) dut2 (
        .clkin(clk), .rst(rst), .tick_in(tick2), .start(start2), .pause(pause2),
        .min_bcd(min2), .sec_tens(tens2), .sec_ones(ones2), .round_num(round2),
        .phase(phase2), .paused(paused2), .bell(bell2), .done(done2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: remaining time in whole seconds, phase 0..3, round, pause flag, bell cycles left.
    int m_phase, m_time, m_round, m_bell;
    bit m_paused, m_tickq;
    int div_cnt = 0;
    int bell_edges = 0;
    bit prev_bell = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_vec();
        return {11'd0, 4'(m_time / 60), 4'((m_time % 60) / 10), 4'(m_time % 10), 4'(m_round),
                2'(m_phase), m_paused, (m_bell > 0), (m_phase == 3)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {11'd0, min_bcd, sec_tens, sec_ones, round_num, phase, paused, bell, done};
    endfunction

    function automatic logic [31:0] pack(int t, int r, int p, bit pz, bit b, bit d);
        return {11'd0, 4'(t / 60), 4'((t % 60) / 10), 4'(t % 10), 4'(r), 2'(p), pz, b, d};
    endfunction

    task automatic model_update();
        bit te, ring, old_p;
        if (!rst) begin
            m_phase = 0; m_time = RT; m_round = 1; m_paused = 0; m_bell = 0; m_tickq = 1;
        end else begin
            te = tick_in && !m_tickq;
            m_tickq = tick_in;
            ring = 0;
            old_p = m_paused;
            if (m_phase == 0) begin
                if (start) begin m_phase = 1; ring = 1; end
            end else if (m_phase == 3) begin
                if (start) begin m_phase = 0; m_time = RT; m_round = 1; end
            end else begin
                if (pause) m_paused = !m_paused;
                if (te && !old_p) begin
                    if (m_time > 0) m_time--;
                    else begin
                        ring = 1;
                        if (m_phase == 1 && m_round == NR) begin m_phase = 3; m_paused = 0; end
                        else if (m_phase == 1) begin m_phase = 2; m_time = RS; end
                        else begin m_phase = 1; m_round++; m_time = RT; end
                    end
                end
            end
            if (ring) m_bell = BL;
            else if (m_bell > 0) m_bell--;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("cycle", dut_vec(), exp_vec());
        if (bell && !prev_bell) bell_edges++;
        prev_bell = bell;
        start = 0; pause = 0; start2 = 0;
        if (!rst) begin
            tick_in = 1; div_cnt = 0;
        end else if (++div_cnt == 5) begin
            div_cnt = 0; tick_in = ~tick_in;
        end
    endtask

    initial begin
        int bell_hi;
        bit hit;
        m_phase = 0; m_time = RT; m_round = 1; m_paused = 0; m_bell = 0; m_tickq = 1;

        // Reset with tick high, then release with no spurious decrement.
        rst = 0;
        repeat (3) step();
        rst = 1;
        repeat (4) step();
        chk("reset_state", dut_vec(), pack(3, 1, 0, 0, 0, 0));

        // Start: bell exactly BELL_LEN cycles, then the whole match to DONE.
        bell_edges = 0;
        start = 1;
        step();
        bell_hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (bell) bell_hi++;
            step();
        end
        chk("bell_len", bell_hi, BL);
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_phase == 3) begin hit = 1; break; end
            step();
        end
        chk("done_reached", hit, 1);
        repeat (5) step();
        chk("done_state", dut_vec(), pack(0, 2, 3, 0, 0, 1));
        chk("bell_pulses", bell_edges, 4);
        start = 1;
        step();
        chk("rearm_idle", dut_vec(), pack(3, 1, 0, 0, 0, 0));

        // Pause at 0:02, let four tick edges pass, resume.
        start = 1;
        step();
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_time == 2) begin hit = 1; break; end
            step();
        end
        chk("reach_0_02", hit, 1);
        pause = 1;
        step();
        repeat (40) step();
        chk("paused_hold", dut_vec(), pack(2, 1, 1, 1, 0, 0));
        pause = 1;
        step();
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            if (m_time == 1) begin hit = 1; break; end
            step();
        end
        chk("resume_0_01", hit, 1);
        chk("resumed", dut_vec(), pack(1, 1, 1, 0, 0, 0));

        // Pause in the same cycle as a tick edge: the decrement still happens.
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (tick_in && !m_tickq) begin hit = 1; break; end
            step();
        end
        chk("edge_found", hit, 1);
        pause = 1;
        step();
        chk("pause_with_tick", dut_vec(), pack(0, 1, 1, 1, 0, 0));
        pause = 1;
        step();

        // Reset while in REST with the bell ringing.
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_phase == 2 && m_bell > 0) begin hit = 1; break; end
            step();
        end
        chk("rest_bell", hit, 1);
        rst = 0;
        step();
        chk("reset_in_rest", dut_vec(), pack(3, 1, 0, 0, 0, 0));
        rst = 1;
        step();

        // Random start/pause/reset traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 19) == 0);
            pause = ($urandom_range(0, 14) == 0);
            rst   = ($urandom_range(0, 399) != 0);
            step();
        end
        rst = 1;
        step();

        // Borrow chain on a 9:59 round.
        tick2 = 0;
        step();
        chk("d2_reset", {min2, tens2, ones2}, 12'h959);
        start2 = 1;
        step();
        for (int k = 1; k <= 60; k++) begin
            tick2 = 1;
            step();
            tick2 = 0;
            step();
            if (k == 1) chk("d2_9_58", {min2, tens2, ones2}, 12'h958);
            if (k == 59) chk("d2_9_00", {min2, tens2, ones2}, 12'h900);
            if (k == 60) chk("d2_8_59", {min2, tens2, ones2}, 12'h859);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
